// File: rtl/gray_code_counter.sv
// Up/down Gray-code counter with a binary shadow, per-edge toggle mask and terminal-count flag.
// Define GRAY_CNT_LOAD_EN to enable the synchronous parallel Gray-code load.
module gray_code_counter #(
  parameter int WIDTH = 4,
  parameter int WRAP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] ld_gray,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] b,
  output logic             tc,
  output logic [WIDTH-1:0] tog
);

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic [WIDTH-1:0] r_tog;
  logic [WIDTH-1:0] w_binNext;
  logic [WIDTH-1:0] w_grayNext;
  logic             w_allOnes;
  logic             w_zero;
  logic             w_holdAtEnd;

  assign w_allOnes = &r_bin;
  assign w_zero    = ~|r_bin;
  assign tc        = en & (up ? w_allOnes : w_zero);

  // Saturating builds stop at the terminal value instead of wrapping.
  assign w_holdAtEnd = (WRAP == 0) && (up ? w_allOnes : w_zero);

`ifdef GRAY_CNT_LOAD_EN
  logic [WIDTH-1:0] w_ldBin;

  // Binary bit i is the XOR of all Gray bits at or above position i.
  always_comb begin
    w_ldBin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_ldBin[i] = ^(ld_gray >> i);
    end
  end

  always_comb begin
    w_binNext = r_bin;
    if (load) begin
      w_binNext = w_ldBin;
    end else if (en && !w_holdAtEnd) begin
      w_binNext = up ? r_bin + 1'b1 : r_bin - 1'b1;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{load, ld_gray};

  always_comb begin
    w_binNext = r_bin;
    if (en && !w_holdAtEnd) begin
      w_binNext = up ? r_bin + 1'b1 : r_bin - 1'b1;
    end
  end
`endif

  assign w_grayNext = w_binNext ^ (w_binNext >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_tog  <= '0;
    end else begin
      r_bin  <= w_binNext;
      r_gray <= w_grayNext;
      r_tog  <= r_gray ^ w_grayNext;
    end
  end

  assign b   = r_bin;
  assign g   = r_gray;
  assign tog = r_tog;

endmodule

// File: tb/tb_gray_code_counter.sv
// Self-checking bench for gray_code_counter: a wrapping and a saturating instance side by side,
// hand-written vectors for the corner cases and a randomized run against a table-based model.
module tb_gray_code_counter;

  localparam int W = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] ldGray;
  logic [W-1:0] g1, b1, tog1, g0, b0, tog0;
  logic         tc1, tc0;

  int testsRun;
  int testsFailed;
  int grayTab[MAXV+1];
  int m1, m0, n1, n0;

  typedef struct {
    logic         en;
    logic         up;
    logic [W-1:0] expG;
    logic [W-1:0] expB;
    logic [W-1:0] expTog;
    logic         expTcBefore;
  } vector_t;

  vector_t vecs[17];

  gray_code_counter #(.WIDTH(W), .WRAP(1)) uWrap (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .ld_gray(ldGray),
    .g(g1), .b(b1), .tc(tc1), .tog(tog1)
  );

  gray_code_counter #(.WIDTH(W), .WRAP(0)) uSat (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .ld_gray(ldGray),
    .g(g0), .b(b0), .tc(tc0), .tog(tog0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic u, input logic l, input logic [W-1:0] lg);
    en = e;
    up = u;
    load = l;
    ldGray = lg;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Reflected construction: each doubling mirrors the existing list and sets the new top bit.
  task automatic buildGrayTable();
    grayTab[0] = 0;
    for (int size = 1; size <= MAXV; size = size * 2) begin
      for (int i = 0; i < size; i++) begin
        grayTab[2*size-1-i] = grayTab[i] | size;
      end
    end
  endtask

  function automatic int grayToIdx(input logic [W-1:0] gv);
    for (int i = 0; i <= MAXV; i++) begin
      if (grayTab[i] == int'(gv)) return i;
    end
    return -1;
  endfunction

  function automatic int modelNext(input int cur, input bit wrap, input logic e, input logic u,
                                   input logic l, input logic [W-1:0] lg);
`ifdef GRAY_CNT_LOAD_EN
    if (l) return grayToIdx(lg);
`endif
    if (!e) return cur;
    if (u) return (cur == MAXV) ? (wrap ? 0 : MAXV) : cur + 1;
    return (cur == 0) ? (wrap ? MAXV : 0) : cur - 1;
  endfunction

  initial begin
    logic [W-1:0] gSeq[17]  = '{4'h1,4'h3,4'h2,4'h6,4'h7,4'h5,4'h4,4'hC,4'hD,4'hF,4'hE,4'hA,4'hB,4'h9,4'h8,4'h0,4'h1};
    logic [W-1:0] togSeq[17] = '{4'h1,4'h2,4'h1,4'h4,4'h1,4'h2,4'h1,4'h8,4'h1,4'h2,4'h1,4'h4,4'h1,4'h2,4'h1,4'h8,4'h1};
    logic [W-1:0] prevG;
    bit           expTc;
    testsRun = 0;
    testsFailed = 0;
    buildGrayTable();
    for (int i = 0; i < 17; i++) begin
      vecs[i].en = 1'b1;
      vecs[i].up = 1'b1;
      vecs[i].expG = gSeq[i];
      vecs[i].expB = W'((i + 1) % 16);
      vecs[i].expTog = togSeq[i];
      vecs[i].expTcBefore = (i == 15);
    end

    // Reset state, and tc while reset is held
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    #7;
    checkOutput("rst_g", 16'(g1), 16'h0);
    checkOutput("rst_b", 16'(b1), 16'h0);
    checkOutput("rst_tog", 16'(tog1), 16'h0);
    checkOutput("rst_tc_idle", 16'(tc1), 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    #1;
    checkOutput("rst_tc_down", 16'(tc1), 16'h1);
    checkOutput("rst_tc_down_sat", 16'(tc0), 16'h1);
    tick();
    checkOutput("rst_hold_b", 16'(b1), 16'h0);

    // Full wrapping up-count sequence from the vector table
    doReset();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].en, vecs[i].up, 1'b0, '0);
      #1;
      checkOutput($sformatf("seq%0d_tc", i), 16'(tc1), 16'(vecs[i].expTcBefore));
      tick();
      checkOutput($sformatf("seq%0d_g", i), 16'(g1), 16'(vecs[i].expG));
      checkOutput($sformatf("seq%0d_b", i), 16'(b1), 16'(vecs[i].expB));
      checkOutput($sformatf("seq%0d_tog", i), 16'(tog1), 16'(vecs[i].expTog));
    end

    // Down from zero wraps to all-ones in one step
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    #1;
    checkOutput("dn_tc_before", 16'(tc1), 16'h1);
    tick();
    checkOutput("dn_b", 16'(b1), 16'hF);
    checkOutput("dn_g", 16'(g1), 16'h8);
    checkOutput("dn_tog", 16'(tog1), 16'h8);
    checkOutput("dn_sat_b", 16'(b0), 16'h0);
    checkOutput("dn_sat_tog", 16'(tog0), 16'h0);

    // Saturating instance pinned at all-ones
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 14; i++) tick();
    checkOutput("sat_pre_b", 16'(b0), 16'hE);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("sat%0d_b", i), 16'(b0), 16'hF);
      checkOutput($sformatf("sat%0d_g", i), 16'(g0), 16'h8);
      checkOutput($sformatf("sat%0d_tog", i), 16'(tog0), (i == 0) ? 16'h1 : 16'h0);
      checkOutput($sformatf("sat%0d_tc", i), 16'(tc0), 16'h1);
    end

    // Asynchronous reset between edges mid-count
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("mid_pre_b", 16'(b1), 16'h5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_async_b", 16'(b1), 16'h0);
    checkOutput("mid_async_g", 16'(g1), 16'h0);
    checkOutput("mid_async_tog", 16'(tog1), 16'h0);
    #1;
    rst_n = 1'b1;
    tick();
    checkOutput("mid_after_b", 16'(b1), 16'h1);
    checkOutput("mid_after_g", 16'(g1), 16'h1);

    // Load against a simultaneous count request
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) tick();
    prevG = g1;
`ifdef GRAY_CNT_LOAD_EN
    applyStimulus(1'b1, 1'b1, 1'b1, 4'hC);
    tick();
    checkOutput("ld_b", 16'(b1), 16'h8);
    checkOutput("ld_g", 16'(g1), 16'hC);
    checkOutput("ld_tog", 16'(tog1), 16'(prevG ^ 4'hC));
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    tick();
    checkOutput("ld_next_b", 16'(b1), 16'h9);
    checkOutput("ld_next_g", 16'(g1), 16'hD);
    checkOutput("ld_next_tog", 16'(tog1), 16'h1);
`else
    applyStimulus(1'b0, 1'b1, 1'b1, 4'hC);
    tick();
    checkOutput("ld_ign_b", 16'(b1), 16'h3);
    checkOutput("ld_ign_g", 16'(g1), 16'(prevG));
    checkOutput("ld_ign_tog", 16'(tog1), 16'h0);
`endif

    // Randomized run against the table-based model
    doReset();
    m1 = 0;
    m0 = 0;
    for (int c = 0; c < 400; c++) begin
      applyStimulus($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 7) == 0, W'($urandom));
      #1;
      expTc = en && (up ? (m1 == MAXV) : (m1 == 0));
      checkOutput("rnd_tc_wrap", 16'(tc1), 16'(expTc));
      expTc = en && (up ? (m0 == MAXV) : (m0 == 0));
      checkOutput("rnd_tc_sat", 16'(tc0), 16'(expTc));
      n1 = modelNext(m1, 1'b1, en, up, load, ldGray);
      n0 = modelNext(m0, 1'b0, en, up, load, ldGray);
      tick();
      checkOutput("rnd_b_wrap", 16'(b1), 16'(n1));
      checkOutput("rnd_g_wrap", 16'(g1), 16'(grayTab[n1]));
      checkOutput("rnd_tog_wrap", 16'(tog1), 16'(grayTab[m1] ^ grayTab[n1]));
      checkOutput("rnd_b_sat", 16'(b0), 16'(n0));
      checkOutput("rnd_g_sat", 16'(g0), 16'(grayTab[n0]));
      checkOutput("rnd_tog_sat", 16'(tog0), 16'(grayTab[m0] ^ grayTab[n0]));
      m1 = n1;
      m0 = n0;
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/gray_code_counter.md
GRAY_CODE_COUNTER -- requirements
Module: gray_code_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter and code width in bits (legal 2..16).
REQ-002 Parameter WRAP, default 1, 1 = modular wrap at terminal value, 0 = saturate at terminal value.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  count enable; counter steps once per clk while high.
REQ-006 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 load  input  1  synchronous parallel load strobe (effective only with GRAY_CNT_LOAD_EN).
REQ-008 ld_gray  input  WIDTH  Gray-coded value captured on load.
REQ-009 g  output  WIDTH  registered Gray-code count.
REQ-010 b  output  WIDTH  registered binary equivalent of g.
REQ-011 tc  output  1  terminal-count flag, combinational from registered state and inputs.
REQ-012 tog  output  WIDTH  registered mask of g bits that changed on the last clock edge.

Function
REQ-013 Internal state is binary register b; g SHALL equal b ^ (b >> 1) at every clock edge, both registered (no combinational path from inputs to g or b).
REQ-014 Per edge, priority: load (when enabled) > en > hold.
REQ-015 en=1, up=1: b <= b+1; en=1, up=0: b <= b-1; en=0 and no load: b, g hold.
REQ-016 WRAP=1: all-ones +1 -> 0, 0 -1 -> all-ones, modulo 2^WIDTH.
REQ-017 WRAP=0: at all-ones with up=1, or at 0 with up=0, b and g hold; no wrap.
REQ-018 tc = en & (up ? b == all-ones : b == 0); independent of WRAP and load.
REQ-019 tog <= g_old ^ g_new on every edge; single one-hot bit on a count step, 0 on hold or saturation, possibly multi-bit on load.
REQ-020 On load: b <= Gray-to-binary of ld_gray (b[WIDTH-1] = ld_gray[WIDTH-1]; b[i] = b[i+1] ^ ld_gray[i] downward); g <= ld_gray.
REQ-021 load and en high in the same cycle: load wins, no count step applied that cycle.
REQ-022 Direction change (up toggles) takes effect on the next enabled edge with no lost or extra step.
REQ-023 Any Gray input value is legal for ld_gray; no illegal codes exist.

Reset
REQ-024 rst_n low SHALL immediately (no clk edge) force b=0, g=0, tog=0.
REQ-025 tc during reset follows REQ-018 with b=0 (tc=1 if en=1, up=0).
REQ-026 Reset asserted mid-count or mid-load aborts the update; first edge after rst_n rises counts from 0 per REQ-014.
REQ-027 rst_n deassertion is synchronised externally; block requires no reset synchroniser.

Configuration
REQ-028 Macro GRAY_CNT_LOAD_EN defined: load/ld_gray behave per REQ-020/021.
REQ-029 Macro undefined: load and ld_gray ports remain present but are ignored; no Gray-to-binary converter logic synthesised; only count/hold occur.

Verification
REQ-030 WIDTH=4, WRAP=1, reset then en=1, up=1 for 17 cycles -> g sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0; tog one-hot every cycle; tc=1 while b=F.
REQ-031 WIDTH=4, WRAP=0, up=1 from b=E for 3 cycles -> b=F, F, F; g=8 held; tog=0 after saturation; tc stays 1.
REQ-032 WRAP=1, up=0 from reset, en=1 one cycle -> b=F, g=8, tog=8; tc=1 before the edge.
REQ-033 GRAY_CNT_LOAD_EN defined, load=1, en=1, ld_gray=0xC -> b=8, g=C, no step; next cycle en=1, up=1 -> b=9, g=D, tog=1.
REQ-034 GRAY_CNT_LOAD_EN undefined, load=1, ld_gray=0xC, en=0 -> b, g unchanged, tog=0.
REQ-035 Mid-count (b=5), rst_n pulsed low between edges -> b=0, g=0, tog=0 asynchronously; after release, en=1, up=1 -> b=1, g=1.
